// File: rtl/line_burst_adaptor_if.sv
// Line-side and burst-side signal bundle for line_burst_adaptor.
// slave = the adaptor's view, master = the environment's view.
interface line_burst_adaptor_if #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
);
  logic [31:0]       pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic [31:0]       burst_address;
  logic              burst_read;
  logic              burst_write;
  logic [BEAT_W-1:0] burst_wdata;
  logic [BEAT_W-1:0] burst_rdata;
  logic              burst_resp;

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp,
    output burst_address, burst_read, burst_write, burst_wdata,
    input  burst_rdata, burst_resp
  );

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp,
    input  burst_address, burst_read, burst_write, burst_wdata,
    output burst_rdata, burst_resp
  );
endinterface

// File: rtl/line_burst_adaptor.sv
// Cache line (256b) to 4-beat 64b burst adaptor with one-cycle line response.
// Optional line counters enabled by LINE_BURST_ADAPTOR_PERF_EN.
module line_burst_adaptor #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int BEATS  = LINE_W / BEAT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  line_burst_adaptor_if.slave     bus,
  output logic [31:0]             rd_line_count,
  output logic [31:0]             wr_line_count
);
  localparam int BW = $clog2(BEATS);
  localparam int SW = $clog2(BEAT_W);
  localparam int IW = BW + SW;

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, DONE
  } state_t;

  state_t            state_q;
  logic [BW-1:0]     beat_q;
  logic [BW-1:0]     beat_nx;
  logic [IW-1:0]     cur_base;
  logic [IW-1:0]     nxt_base;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wline_q;
  logic [LINE_W-1:0] rdata_q;
  logic [BEAT_W-1:0] wdata_q;
  logic              resp_q;
  logic              brd_q;
  logic              bwr_q;
  logic              last_beat;
  logic              unused_ok;

  assign beat_nx   = beat_q + 1'b1;
  assign cur_base  = {beat_q, {SW{1'b0}}};
  assign nxt_base  = {beat_nx, {SW{1'b0}}};
  assign last_beat = bus.burst_resp &&
                     (beat_q == BW'(BEATS - 1));
  assign unused_ok = ^bus.pmem_address[4:0];

  assign bus.pmem_rdata    = rdata_q;
  assign bus.pmem_resp     = resp_q;
  assign bus.burst_address = addr_q;
  assign bus.burst_read    = brd_q;
  assign bus.burst_write   = bwr_q;
  assign bus.burst_wdata   = wdata_q;

  // Transaction FSM: latch request, run the burst, pulse the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      resp_q  <= 1'b0;
      brd_q   <= 1'b0;
      bwr_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          beat_q <= '0;
          if (bus.pmem_write) begin
            addr_q  <= {bus.pmem_address[31:5], 5'b0};
            wline_q <= bus.pmem_wdata;
            wdata_q <= bus.pmem_wdata[BEAT_W-1:0];
            bwr_q   <= 1'b1;
            state_q <= WRITE;
          end else if (bus.pmem_read) begin
            addr_q  <= {bus.pmem_address[31:5], 5'b0};
            brd_q   <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          if (bus.burst_resp) begin
            rdata_q[cur_base +: BEAT_W] <= bus.burst_rdata;
            beat_q <= beat_nx;
          end
          if (last_beat) begin
            brd_q   <= 1'b0;
            resp_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        WRITE: begin
          if (bus.burst_resp) begin
            beat_q  <= beat_nx;
            wdata_q <= wline_q[nxt_base +: BEAT_W];
          end
          if (last_beat) begin
            bwr_q   <= 1'b0;
            resp_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          resp_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LINE_BURST_ADAPTOR_PERF_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  // Count completed lines; the new value is visible in the DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (state_q == READ && last_beat)
        rd_cnt_q <= rd_cnt_q + 32'd1;
      if (state_q == WRITE && last_beat)
        wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_line_count = rd_cnt_q;
  assign wr_line_count = wr_cnt_q;
`else
  assign rd_line_count = '0;
  assign wr_line_count = '0;
`endif

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Scoreboard bench for line_burst_adaptor.
// Expected lines/beats are queued at request time and popped on output.
module tb_line_burst_adaptor;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] rd_line_count;
  logic [31:0] wr_line_count;

  line_burst_adaptor_if bus ();

  line_burst_adaptor dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .rd_line_count (rd_line_count),
    .wr_line_count (wr_line_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_rd  = 0;
  int n_wr  = 0;
  logic [255:0] last_rd = '0;
  logic [255:0] exp_line[$];
  logic [63:0]  exp_beat[$];

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_resp"},  bus.pmem_resp, 0);
    chk({tag, "_brd"},   bus.burst_read, 0);
    chk({tag, "_bwr"},   bus.burst_write, 0);
    chk({tag, "_baddr"}, bus.burst_address, 0);
    chk({tag, "_bwd"},   bus.burst_wdata, 0);
    chk({tag, "_rdat"},  bus.pmem_rdata, 0);
  endtask

  task automatic run_txn(input bit wr, input bit rd,
                         input logic [31:0] addr,
                         input logic [255:0] line,
                         input logic [15:0] pat,
                         input int exp_lat);
    int bi;
    int last;
    bit iswr;
    logic [63:0] e;
    logic [255:0] el;
    bi   = 0;
    last = -1;
    iswr = wr;
    @(posedge clk); #1;
    bus.pmem_read    = rd;
    bus.pmem_write   = wr;
    bus.pmem_address = addr;
    bus.pmem_wdata   = wr ? line : {8{$urandom}};
    bus.burst_resp   = 1'b0;
    if (iswr)
      for (int b = 0; b < 4; b++) exp_beat.push_back(line[b*64 +: 64]);
    else
      exp_line.push_back(line);
    for (int c = 1; c < 40 && bi < 4; c++) begin
      @(posedge clk); #1;
      bus.burst_resp  = pat[c];
      bus.burst_rdata = pat[c] ? line[bi*64 +: 64] : {$urandom, $urandom};
      @(negedge clk);
      chk("baddr", bus.burst_address, {addr[31:5], 5'b0});
      chk("bwr",   bus.burst_write, iswr);
      chk("brd",   bus.burst_read, !iswr);
      chk("early_resp", bus.pmem_resp, 0);
      if (bus.burst_resp) begin
        if (iswr) begin
          e = exp_beat.pop_front();
          chk("wbeat", bus.burst_wdata, e);
        end
        bi++;
        last = c;
      end
    end
    if (bi < 4) chk("timeout_beats", bi, 4);
    @(posedge clk); #1;
    bus.burst_resp = 1'b0;
    @(negedge clk);
    chk("resp",     bus.pmem_resp, 1);
    chk("brd_off",  bus.burst_read, 0);
    chk("bwr_off",  bus.burst_write, 0);
    if (!iswr) begin
      el = exp_line.pop_front();
      chk("rline", bus.pmem_rdata, el);
      last_rd = el;
      n_rd++;
    end else begin
      chk("rkeep", bus.pmem_rdata, last_rd);
      n_wr++;
    end
    if (exp_lat > 0) chk("latency", last + 1, exp_lat);
    @(posedge clk); #1;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    @(negedge clk);
    chk("one_pulse", bus.pmem_resp, 0);
    chk("idle_brd",  bus.burst_read, 0);
    chk("idle_bwr",  bus.burst_write, 0);
  endtask

  logic [255:0] l_rd;
  logic [255:0] l_wr;

  initial begin
    rst = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_wdata   = '0;
    bus.burst_rdata  = '0;
    bus.burst_resp   = 1'b0;
    #3;
    chk_zero("rst0");
    chk("rst0_rdcnt", rd_line_count, 0);
    chk("rst0_wrcnt", wr_line_count, 0);
    @(negedge clk);
    rst = 1'b1;

    // Abort a read after two beats with an async reset.
    @(posedge clk); #1;
    bus.pmem_read    = 1'b1;
    bus.pmem_address = 32'h0000_5678;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    bus.burst_resp = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_zero("abort");
    bus.pmem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last_rd = '0;

    l_rd = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    run_txn(0, 1, 32'h0000_1234, {8{$urandom}}, 16'h001E, 5);
    run_txn(0, 1, 32'h8000_00FF, l_rd, 16'h001E, 5);

    l_wr = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    run_txn(1, 0, 32'hCAFE_BEEF, l_wr, 16'h0264, 10);

    run_txn(1, 1, 32'h0000_0040, {8{$urandom}}, 16'h00AA, 0);

    run_txn(0, 1, 32'h1111_1111, {8{$urandom}}, 16'h001E, 5);
    run_txn(0, 1, 32'h2222_2222, {8{$urandom}}, 16'h0156, 0);

    // Stray burst_resp while idle must not start anything.
    @(posedge clk); #1;
    bus.burst_resp = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.burst_resp = 1'b0;
    @(negedge clk);
    chk("stray_brd",  bus.burst_read, 0);
    chk("stray_resp", bus.pmem_resp, 0);
    chk("stray_rdat", bus.pmem_rdata, last_rd);

`ifdef LINE_BURST_ADAPTOR_PERF_EN
    chk("rd_count", rd_line_count, n_rd);
    chk("wr_count", wr_line_count, n_wr);
`else
    chk("rd_count", rd_line_count, 0);
    chk("wr_count", wr_line_count, 0);
`endif
    chk("sb_empty", exp_line.size() + exp_beat.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/line_burst_adaptor.md
Name: line_burst_adaptor

Overview:
- Memory-side responder for the cache's 256-bit line interface (pmem_*); it answers every line read/write the cache datapath initiates.
- Converts each line request into a 4-beat, 64-bit burst transaction on the physical-memory port, then returns a single-cycle line response.
- Sits between the cache controller/datapath and the burst memory model or arbiter.

Parameters:
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, burst beat width in bits.
- BEATS, LINE_W/BEAT_W (4), beats per line; must be a power of two ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- pmem_address  in  32  line address from cache; bits [4:0] ignored.
- pmem_read  in  1  line read request; held until pmem_resp.
- pmem_write  in  1  line write request; held until pmem_resp.
- pmem_wdata  in  LINE_W  line to write; stable while pmem_write is high.
- pmem_rdata  out  LINE_W  assembled read line.
- pmem_resp  out  1  one-cycle completion pulse.
- burst_address  out  32  line-aligned burst address.
- burst_read  out  1  burst read request.
- burst_write  out  1  burst write request.
- burst_wdata  out  BEAT_W  current write beat.
- burst_rdata  in  BEAT_W  returned read beat.
- burst_resp  in  1  beat accepted/valid this cycle.
- rd_line_count  out  32  completed line reads (optional feature).
- wr_line_count  out  32  completed line writes (optional feature).

Behaviour:
- Reset (rst low, async): state IDLE; beat counter 0; pmem_resp, burst_read, burst_write 0; burst_address, burst_wdata, pmem_rdata, both counts 0. Reset mid-burst aborts immediately with no response.
- States: IDLE, READ, WRITE, DONE.
- IDLE: on pmem_write, latch {pmem_address[31:5],5'b0} and pmem_wdata; go to WRITE. Else on pmem_read, latch the address and go to READ. If both are high, the write wins (protocol violation, cache never does this).
- burst_read/burst_write are registered: asserted the cycle after the request is sampled in IDLE, held continuously until the cycle the final beat's burst_resp is seen, then deasserted the next edge.
- READ: each cycle with burst_resp=1 stores burst_rdata into slice [beat*BEAT_W +: BEAT_W] of pmem_rdata (beat 0 = LSBs) and increments the beat counter. burst_resp may be non-contiguous; gaps stall. After beat BEATS-1, go to DONE.
- WRITE: burst_wdata = latched line slice for the current beat, valid from the cycle burst_write rises. It advances to the next slice on the edge after each burst_resp. After beat BEATS-1, go to DONE.
- DONE: pmem_resp=1 for exactly one cycle, then IDLE. The request still being high in the DONE cycle is not a new request. A new request is sampled only from the next IDLE cycle.
- Minimum latency (contiguous resp): request at cycle 0 → burst asserted at cycle 1 → beats at cycles 1..4 → pmem_resp at cycle 5.
- pmem_rdata holds the last completed read line until the next read overwrites it. Writes never alter pmem_rdata.
- Beat counter width is log2(BEATS) and wraps to 0 at line completion.
- burst_address is constant for the whole transaction. The low 5 bits are always 0.
- burst_resp while in IDLE or DONE is ignored.

Optional Feature:
- Macro: LINE_BURST_ADAPTOR_PERF_EN.
- Defined: rd_line_count / wr_line_count increment by 1 in the DONE cycle of each read / write. They wrap at 2^32 and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are inferred. Port list is unchanged.

Test Plan:
- Reset: rst low mid-READ after 2 beats → all outputs 0 and state IDLE at once. After release, pmem_read at 0x0000_1234 → burst_address 0x0000_1220 and a full 4-beat fresh read.
- Contiguous read: burst_rdata beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → pmem_rdata = {0x44..,0x33..,0x22..,0x11..}; pmem_resp high exactly at cycle 5.
- Stalled write: pmem_wdata = 256'h…DDDD_CCCC_BBBB_AAAA pattern; burst_resp asserted on cycles 2, 5, 6, 9 → burst_wdata sequence AAAA, BBBB, CCCC, DDDD slices; burst_write held throughout; pmem_resp one cycle after the last beat.
- Simultaneous pmem_read and pmem_write in IDLE → burst_write is asserted, burst_read stays 0, and pmem_rdata is unchanged.
- Back-to-back: request held high through DONE → exactly one pmem_resp pulse. A second read issued the cycle after resp completes normally.
- Perf: with LINE_BURST_ADAPTOR_PERF_EN, 3 reads and 2 writes → rd_line_count=3, wr_line_count=2. Without the macro, both read 0.
